// File: rtl/ycr2_mem_wb_bridge.sv
// Core-side memory request to Wishbone classic bridge.
// Executes single or incrementing-burst requests as per-beat bus cycles.
module ycr2_mem_wb_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int BLW     = 3,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_req,
    input  logic            core_cmd,
    input  logic [1:0]      core_width,
    input  logic [AW-1:0]   core_addr,
    input  logic [BLW-1:0]  core_bl,
    input  logic [DW-1:0]   core_wdata,
    output logic            core_req_ack,
    output logic [DW-1:0]   core_rdata,
    output logic [1:0]      core_resp,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i
);

    localparam int SW = DW / 8;

    localparam logic [1:0] RSP_OK  = 2'b01;
    localparam logic [1:0] RSP_ER  = 2'b10;
    localparam logic [1:0] RSP_LOK = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic           cmd_q, cmd_d;
    logic [1:0]     width_q, width_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [BLW-1:0] beats_q, beats_d;
    logic [BLW-1:0] idx_q, idx_d;
    logic [15:0]    tmo_q, tmo_d;
    logic [1:0]     resp_q, resp_d;
    logic [DW-1:0]  rdata_q, rdata_d;

    logic           misaligned;
    logic           last_beat;
    logic           tmo_hit;
    logic [AW-1:0]  base_adr;
    logic [AW-1:0]  beat_adr;
    logic [SW-1:0]  sel0;

    assign misaligned = ((core_width == 2'd1) && core_addr[0]) ||
                        (core_width[1] && (core_addr[1:0] != 2'b00));
    assign last_beat  = (idx_q == beats_q - 1'b1);
    assign tmo_hit    = (tmo_q == 16'(TIMEOUT - 1));

    // Follow-on beats are word aligned regardless of the first byte offset.
    assign base_adr = (idx_q == '0) ? addr_q : {addr_q[AW-1:2], 2'b00};
    assign beat_adr = base_adr + AW'({idx_q, 2'b00});

    always_comb begin
        sel0 = '1;
        if (width_q == 2'd0)
            sel0 = SW'(1) << addr_q[1:0];
        else if (width_q == 2'd1)
            sel0 = addr_q[1] ? SW'(4'b1100) : SW'(4'b0011);
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        width_d      = width_q;
        addr_d       = addr_q;
        beats_d      = beats_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        resp_d       = resp_q;
        rdata_d      = rdata_q;
        core_req_ack = 1'b0;
        core_resp    = 2'b00;
        core_rdata   = '0;
        wbm_cyc_o    = 1'b0;
        wbm_stb_o    = 1'b0;
        wbm_we_o     = 1'b0;
        wbm_adr_o    = '0;
        wbm_sel_o    = '0;
        wbm_dat_o    = '0;
        unique case (state_q)
            IDLE: begin
                core_req_ack = core_req & rst_n;
                if (core_req) begin
                    cmd_d   = core_cmd;
                    width_d = core_width;
                    addr_d  = core_addr;
                    beats_d = (core_bl == '0) ? BLW'(1) : core_bl;
                    idx_d   = '0;
                    tmo_d   = '0;
                    if (misaligned) begin
                        resp_d  = RSP_ER;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = cmd_q;
                wbm_adr_o = beat_adr;
                wbm_sel_o = (idx_q == '0) ? sel0 : '1;
                wbm_dat_o = core_wdata;
                tmo_d     = tmo_q + 16'd1;
                if (wbm_err_i) begin
                    resp_d  = RSP_ER;
                    rdata_d = '0;
                    state_d = RESP;
                end else if (wbm_ack_i) begin
                    resp_d  = last_beat ? RSP_LOK : RSP_OK;
                    rdata_d = cmd_q ? '0 : wbm_dat_i;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    resp_d  = RSP_ER;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                core_resp  = resp_q;
                core_rdata = rdata_q;
                wbm_cyc_o  = (resp_q == RSP_OK);
                if (resp_q == RSP_OK) begin
                    idx_d   = idx_q + 1'b1;
                    tmo_d   = '0;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= 1'b0;
            width_q <= 2'b00;
            addr_q  <= '0;
            beats_q <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            resp_q  <= 2'b00;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            width_q <= width_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ycr2_mem_wb_bridge.sv
// Bench for ycr2_mem_wb_bridge: scripted and random transactions
// against a per-beat reference model and a scripted Wishbone slave.
module tb_ycr2_mem_wb_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req = 1'b0;
    logic        core_cmd = 1'b0;
    logic [1:0]  core_width = 2'd0;
    logic [31:0] core_addr = '0;
    logic [2:0]  core_bl = '0;
    logic [31:0] core_wdata = '0;
    logic        core_req_ack;
    logic [31:0] core_rdata;
    logic [1:0]  core_resp;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ycr2_mem_wb_bridge #(
        .AW(32), .DW(32), .BLW(3), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_cmd(core_cmd),
        .core_width(core_width), .core_addr(core_addr),
        .core_bl(core_bl), .core_wdata(core_wdata),
        .core_req_ack(core_req_ack), .core_rdata(core_rdata),
        .core_resp(core_resp),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o), .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i)
    );

    // ack, resp, rdata, cyc, stb, we, adr, sel, dat_o
    function automatic logic [105:0] snap();
        return {core_req_ack, core_resp, core_rdata, wbm_cyc_o,
                wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o};
    endfunction

    // One request, with the bench acting as master and slave.
    task automatic do_txn(
        input bit          cmd,
        input logic [1:0]  w,
        input logic [31:0] a,
        input logic [2:0]  bl,
        input logic [31:0] wd0,
        input logic [31:0] rd0,
        input bit          rnd,
        input int          wmin,
        input int          wmax,
        input int          err_beat,
        input bit          hang,
        input int          rst_beat
    );
        int          beats;
        bit          mis;
        logic [31:0] eadr;
        logic [3:0]  esel;
        logic [31:0] rd;
        logic [31:0] cur_wd;
        logic [1:0]  eresp;
        logic [105:0] exp_v;
        int          lim;
        bit          bad;
        beats = (bl == 3'd0) ? 1 : int'(bl);
        mis = (w == 2'd1 && a[0]) || (w >= 2'd2 && a[1:0] != 2'd0);
        @(negedge clk);
        core_req   = 1'b1;
        core_cmd   = cmd;
        core_width = w;
        core_addr  = a;
        core_bl    = bl;
        cur_wd     = wd0;
        core_wdata = cur_wd;
        #1;
        nvec++;
        if ({core_req_ack, core_resp, wbm_cyc_o} !== 4'b1000) begin
            nerr++;
            $display("FAIL accept: ack/resp/cyc=%b want 1000",
                     {core_req_ack, core_resp, wbm_cyc_o});
        end
        @(negedge clk);
        core_req   = 1'b0;
        core_cmd   = ~cmd;
        core_width = 2'($urandom);
        core_addr  = $urandom;
        core_bl    = 3'($urandom);
        if (mis) begin
            nvec++;
            if ({wbm_cyc_o, wbm_stb_o, core_resp} !== 4'b0010) begin
                nerr++;
                $display("FAIL misaligned: cyc/stb/resp=%b want 0010",
                         {wbm_cyc_o, wbm_stb_o, core_resp});
            end
            return;
        end
        for (int b = 0; b < beats; b++) begin
            if (b == 0) begin
                eadr = a;
                case (w)
                    2'd0:    esel = 4'b0001 << a[1:0];
                    2'd1:    esel = a[1] ? 4'b1100 : 4'b0011;
                    default: esel = 4'b1111;
                endcase
            end else begin
                eadr = (a & 32'hFFFF_FFFC) + 32'(4 * b);
                esel = 4'b1111;
            end
            rd  = rnd ? $urandom : rd0 + 32'(b);
            lim = hang ? TMO - 1 : int'($urandom_range(wmax, wmin));
            for (int k = 0; k <= lim; k++) begin
                exp_v = {1'b0, 2'b00, 32'h0, 1'b1, 1'b1, cmd,
                         eadr, esel, cur_wd};
                nvec++;
                if (snap() !== exp_v) begin
                    nerr++;
                    $display("FAIL access b%0d k%0d: got %h want %h",
                             b, k, snap(), exp_v);
                end
                if (b == rst_beat) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    nvec++;
                    if (snap() !== 106'h0) begin
                        nerr++;
                        $display("FAIL reset_mid: got %h want 0", snap());
                    end
                    rst_n = 1'b1;
                    return;
                end
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
                wbm_dat_i = $urandom;
                if (!hang && k == lim) begin
                    wbm_dat_i = rd;
                    if (b == err_beat) wbm_err_i = 1'b1;
                    else wbm_ack_i = 1'b1;
                end
                @(negedge clk);
            end
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            bad = hang || (b == err_beat);
            eresp = bad ? 2'b10 : ((b == beats - 1) ? 2'b11 : 2'b01);
            nvec++;
            if ({wbm_cyc_o, wbm_stb_o, core_resp} !==
                {eresp == 2'b01, 1'b0, eresp}) begin
                nerr++;
                $display("FAIL resp b%0d: cyc/stb/resp=%b want %b", b,
                         {wbm_cyc_o, wbm_stb_o, core_resp},
                         {eresp == 2'b01, 1'b0, eresp});
            end
            if (!bad) begin
                nvec++;
                if (core_rdata !== (cmd ? 32'h0 : rd)) begin
                    nerr++;
                    $display("FAIL rdata b%0d: got %h want %h", b,
                             core_rdata, cmd ? 32'h0 : rd);
                end
            end
            if (eresp != 2'b01) return;
            cur_wd     = $urandom;
            core_wdata = cur_wd;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        core_req = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if (snap() !== 106'h0) begin
            nerr++;
            $display("FAIL reset: got %h want 0", snap());
        end
        core_req = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_single_read();
        do_txn(0, 2'd2, 32'h100, 3'd1, 32'h0, 32'hDEADBEEF,
               0, 0, 0, -1, 0, -1);
    endtask

    task automatic test_byte_write();
        do_txn(1, 2'd0, 32'h203, 3'd1, 32'hAA000000, 32'h0,
               1, 3, 3, -1, 0, -1);
    endtask

    task automatic test_burst_read();
        do_txn(0, 2'd2, 32'h400, 3'd4, 32'h0, 32'h1,
               0, 0, 0, -1, 0, -1);
        do_txn(1, 2'd1, 32'h802, 3'd0, 32'h12345678, 32'h0,
               1, 0, 2, -1, 0, -1);
    endtask

    task automatic test_burst_err();
        do_txn(0, 2'd2, 32'h500, 3'd4, 32'h0, 32'h0,
               1, 0, 1, 1, 0, -1);
    endtask

    task automatic test_misaligned();
        do_txn(0, 2'd1, 32'h101, 3'd1, 32'h0, 32'h0, 1, 0, 0, -1, 0, -1);
        do_txn(1, 2'd3, 32'h102, 3'd2, 32'h0, 32'h0, 1, 0, 0, -1, 0, -1);
    endtask

    task automatic test_timeout();
        do_txn(0, 2'd2, 32'h600, 3'd1, 32'h0, 32'h0, 1, 0, 0, -1, 1, -1);
        do_txn(1, 2'd2, 32'h640, 3'd3, 32'h0, 32'h0, 1, 0, 0, -1, 1, -1);
    endtask

    task automatic test_reset_mid_burst();
        do_txn(0, 2'd2, 32'h700, 3'd4, 32'h0, 32'h0, 1, 0, 1, -1, 0, 2);
        do_txn(0, 2'd2, 32'h700, 3'd1, 32'h0, 32'h0, 1, 0, 1, -1, 0, -1);
    endtask

    task automatic test_wrap();
        do_txn(0, 2'd0, 32'hFFFF_FFF9, 3'd4, 32'h0, 32'h0,
               1, 0, 1, -1, 0, -1);
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] a;
        logic [2:0]  bl;
        int          beats;
        int          eb;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(1, 0) == 0) a[1:0] = 2'b00;
            bl    = 3'($urandom);
            beats = (bl == 3'd0) ? 1 : int'(bl);
            eb    = ($urandom_range(3, 0) == 0) ?
                    int'($urandom_range(beats - 1, 0)) : -1;
            do_txn(1'($urandom), 2'($urandom), a, bl, $urandom, 32'h0,
                   1, 0, 3, eb, $urandom_range(7, 0) == 0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_byte_write();
        test_burst_read();
        test_burst_err();
        test_misaligned();
        test_timeout();
        test_reset_mid_burst();
        test_wrap();
        test_back_to_back_random();
        @(negedge clk);
        nvec++;
        if ({wbm_cyc_o, core_resp} !== 3'b000) begin
            nerr++;
            $display("FAIL final_idle: cyc/resp=%b want 000",
                     {wbm_cyc_o, core_resp});
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
